// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and widths for the UART word arbiter
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } uart_state_e;

  localparam int UART_WORD_W = 32;
  localparam int UART_BYTE_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts after ptr
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  always_comb begin
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    // Offsets 1..N visit every index once, ending on ptr itself as lowest priority.
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_word_arbiter.sv
// rtl/uart_word_arbiter.sv - round-robin share of one byte UART transmitter between word requesters
module uart_word_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int BYTES_PER_WORD = 4,
  parameter int GAP_CYCLES     = 0,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_WORD_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_valid,
  output logic [UART_BYTE_W-1:0]         tx_byte,
  input  logic                           tx_ready,
  output logic                           busy,
  output logic [IDX_W-1:0]               grant_id
);

  localparam int BCW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  uart_state_e            state;
  logic [UART_WORD_W-1:0] shreg;
  logic [BCW-1:0]         byte_cnt;
  logic [15:0]            gap_cnt;
  logic [IDX_W-1:0]       rr_ptr;

  logic [NUM_REQ-1:0]     win_grant;
  logic [IDX_W-1:0]       win_idx;
  logic                   any_req;
  logic [UART_WORD_W-1:0] win_word;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (win_grant),
    .grant_idx (win_idx),
    .any_req   (any_req)
  );

  assign win_word = req_data[int'(win_idx)*UART_WORD_W +: UART_WORD_W];

  // Gated by reset so no handshake can complete while the block is held in reset.
  assign req_ready = (state == ST_IDLE && !reset) ? win_grant : '0;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      tx_valid <= 1'b0;
      tx_byte  <= '0;
      grant_id <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      rr_ptr   <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            shreg    <= win_word;
            tx_byte  <= win_word[UART_WORD_W-1 -: UART_BYTE_W];
            tx_valid <= 1'b1;
            grant_id <= win_idx;
            rr_ptr   <= win_idx;
            byte_cnt <= '0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            shreg   <= {shreg[UART_WORD_W-UART_BYTE_W-1:0], {UART_BYTE_W{1'b0}}};
            tx_byte <= shreg[UART_WORD_W-UART_BYTE_W-1 -: UART_BYTE_W];
            if (byte_cnt == BCW'(BYTES_PER_WORD - 1)) begin
              tx_valid <= 1'b0;
              byte_cnt <= '0;
              gap_cnt  <= '0;
              state    <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == 16'(GAP_CYCLES - 1)) begin
            gap_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_arbiter.sv
// tb/tb_uart_word_arbiter.sv - scoreboard bench for uart_word_arbiter
module tb_uart_word_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic [0:0]  grant_id;

  logic [1:0]  g_req_valid = '0;
  logic [63:0] g_req_data = 64'h0000_0000_0BAD_F00D;
  logic [1:0]  g_req_ready;
  logic        g_tx_valid;
  logic [7:0]  g_tx_byte;
  logic        g_busy;
  logic [0:0]  g_grant_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pend [2] = '{0, 0};
  logic [1:0] hs;

  logic [1:0] exp_grant [$];
  logic [8:0] exp_bytes [$];
  int         xfer_cyc  [$];

  always #5 clk = ~clk;

  uart_word_arbiter #(.NUM_REQ(2), .BYTES_PER_WORD(4), .GAP_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .tx_ready(tx_ready), .busy(busy), .grant_id(grant_id)
  );

  uart_word_arbiter #(.NUM_REQ(2), .BYTES_PER_WORD(4), .GAP_CYCLES(3)) dut_g (
    .clk(clk), .reset(reset), .req_valid(g_req_valid), .req_data(g_req_data),
    .req_ready(g_req_ready), .tx_valid(g_tx_valid), .tx_byte(g_tx_byte),
    .tx_ready(1'b1), .busy(g_busy), .grant_id(g_grant_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic push_word(input int id, input logic [31:0] w);
    exp_grant.push_back(2'(1 << id));
    for (int b = 3; b >= 0; b--) exp_bytes.push_back({1'(id), w[8*b +: 8]});
  endtask

  // One clock step: sample handshakes, then drive just after the edge.
  task automatic tick();
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (hs[i]) begin
        if (pend[i] > 0) pend[i]--;
        if (pend[i] == 0) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || exp_grant.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) fail({name, " drain timeout"});
  endtask

  // Monitor: compares every grant and every byte transfer against the queues.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (req_ready != 2'b00) begin
          if (exp_grant.size() == 0) fail($sformatf("unexpected grant %b", req_ready));
          else check("grant", 32'(req_ready), 32'(exp_grant.pop_front()));
        end
        if (tx_valid && tx_ready) begin
          xfer_cyc.push_back(cyc);
          if (exp_bytes.size() == 0) fail($sformatf("unexpected byte %h", tx_byte));
          else begin
            logic [8:0] e;
            e = exp_bytes.pop_front();
            check("tx_byte", 32'(tx_byte), 32'(e[7:0]));
            check("grant_id", 32'(grant_id), 32'(e[8]));
          end
        end
      end
    end
  end

  initial begin
    int base;
    int g1, g2, ngr, gapc;

    #1;
    check("rst req_ready", 32'(req_ready), 0);
    check("rst tx_valid", 32'(tx_valid), 0);
    check("rst tx_byte", 32'(tx_byte), 0);
    check("rst busy", 32'(busy), 0);
    check("rst grant_id", 32'(grant_id), 0);
    tick();
    reset = 1'b0;
    tick();

    // Single word from requester 0, valid dropped after capture.
    req_data[31:0] = 32'hDEADBEEF;
    pend[0] = 1;
    req_valid = 2'b01;
    push_word(0, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) tick();
    check("single busy before last", 32'(busy), 1);
    tick();
    check("single busy after last", 32'(busy), 0);
    check("single grant_id", 32'(grant_id), 0);
    for (int i = 0; i < 4; i++) tick();

    // Round-robin from reset: 0,1,0,1 with one idle cycle between words.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_data = {32'h22222222, 32'h11111111};
    pend[0] = 2;
    pend[1] = 2;
    req_valid = 2'b11;
    base = xfer_cyc.size();
    push_word(0, 32'h11111111);
    push_word(1, 32'h22222222);
    push_word(0, 32'h11111111);
    push_word(1, 32'h22222222);
    drain("rr");
    if (xfer_cyc.size() >= base + 16) begin
      check("rr gap between words", 32'(xfer_cyc[base+4] - xfer_cyc[base+3]), 2);
      check("rr span 4 words", 32'(xfer_cyc[base+15] - xfer_cyc[base]), 18);
    end else fail("rr transfer count");

    // Backpressure: transmitter stalled with the first byte presented.
    tx_ready = 1'b0;
    req_data[31:0] = 32'hA5C30F96;
    pend[0] = 1;
    req_valid = 2'b01;
    push_word(0, 32'hA5C30F96);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall tx_valid", 32'(tx_valid), 1);
      check("stall tx_byte", 32'(tx_byte), 32'hA5);
      tick();
    end
    tx_ready = 1'b1;
    drain("stall");

    // Reset mid-word: requester 1 loses its word after two bytes.
    req_data[63:32] = 32'h12345678;
    pend[1] = 1;
    req_valid = 2'b10;
    exp_grant.push_back(2'b10);
    exp_bytes.push_back({1'b1, 8'h12});
    exp_bytes.push_back({1'b1, 8'h34});
    for (int i = 0; i < 3; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    check("midrst tx_valid", 32'(tx_valid), 0);
    check("midrst busy", 32'(busy), 0);
    check("midrst tx_byte", 32'(tx_byte), 0);
    req_data[31:0] = 32'hCAFEF00D;
    pend[0] = 1;
    pend[1] = 1;
    req_valid = 2'b11;
    #1;
    check("midrst req_ready", 32'(req_ready), 0);
    tick();
    reset = 1'b0;
    push_word(0, 32'hCAFEF00D);
    push_word(1, 32'h12345678);
    drain("after reset");
    for (int i = 0; i < 4; i++) tick();

    // Gap instance: 3 gap cycles, grant period 8 with valid held.
    g_req_valid = 2'b01;
    ngr = 0;
    g1 = 0;
    g2 = 0;
    gapc = 0;
    for (int n = 0; n < 40 && ngr < 2; n++) begin
      @(negedge clk);
      if (g_req_ready != 2'b00) begin
        check("gap grant", 32'(g_req_ready), 32'b01);
        if (ngr == 0) g1 = n; else g2 = n;
        ngr++;
      end else if (ngr == 1 && g_busy && !g_tx_valid) gapc++;
      if (ngr == 1 && n == g1 + 1) check("gap first byte", 32'(g_tx_byte), 32'h0B);
    end
    g_req_valid = 2'b00;
    if (ngr < 2) fail("gap grant timeout");
    else begin
      check("gap idle cycles", 32'(gapc), 3);
      check("gap grant period", 32'(g2 - g1), 8);
      check("gap grant_id", 32'(g_grant_id), 0);
    end

    check("exp bytes left", 32'(exp_bytes.size()), 0);
    check("exp grants left", 32'(exp_grant.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_word_arbiter.md
Name: uart_word_arbiter

Overview:
- Shares one byte-level UART transmitter between NUM_REQ requesters, e.g. CPU store path and debug/status dump.
- Each requester offers a 32-bit word through a valid/ready handshake.
- The block grants requesters round-robin and holds the grant for the whole word.
- It serialises the granted word MSB byte first to the transmitter over a tx_valid/tx_ready handshake, then waits an optional inter-word gap.
- It sits between the SoC register/CPU side and the UART shifter.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- BYTES_PER_WORD, 4, bytes sent per granted word; always taken from the MSB end of the 32-bit word.
- GAP_CYCLES, 0, idle clk cycles inserted after the last byte is accepted, before the next arbitration (0..65535).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i: requester i has a word pending.
- req_data  input  32*NUM_REQ  word of requester i at bits [32*i+31:32*i]; must be stable while req_valid[i] is high.
- req_ready  output  NUM_REQ  one-hot pulse; word i is captured on the cycle req_valid[i] && req_ready[i].
- tx_valid  output  1  tx_byte holds a byte for the transmitter.
- tx_byte  output  8  byte to transmit.
- tx_ready  input  1  transmitter accepts tx_byte this cycle (tx_valid && tx_ready = transfer).
- busy  output  1  high in every state except IDLE.
- grant_id  output  $clog2(NUM_REQ) (min 1)  index of the current/last granted requester.

Behaviour:
- Reset values (async, immediate): state=IDLE, req_ready=0, tx_valid=0, tx_byte=0, busy=0, grant_id=0, byte counter=0, gap counter=0, rr pointer=NUM_REQ-1. Requester 0 therefore has first priority after reset.
- IDLE:
  - If any req_valid is set, select the first set bit searching from rr pointer+1, wrapping modulo NUM_REQ.
  - Drive req_ready for that bit only, combinationally, in this same cycle.
  - On that edge: capture the word into a shift register, set grant_id and rr pointer to the winner, set byte counter=0, go to SEND.
  - Latency: req_valid high in IDLE gives capture on the same edge.
- SEND:
  - tx_valid=1; tx_byte = shift register bits [31:24], registered.
  - On tx_valid && tx_ready: shift the register left by 8 and increment the byte counter.
  - If the byte counter was BYTES_PER_WORD-1, clear tx_valid: go to GAP if GAP_CYCLES>0, else to IDLE.
  - tx_byte and tx_valid stay stable while tx_ready=0; a stalled transmitter holds the byte indefinitely.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - No grants during GAP.
- req_ready is 0 outside IDLE. A requester dropping req_valid mid-word has no effect, because the word is already captured.
- A requester that keeps req_valid high is re-granted only after every other pending requester has been served. This bounds starvation at NUM_REQ-1 words.
- Back-to-back with GAP_CYCLES=0: IDLE→SEND costs one cycle. Minimum period per word = BYTES_PER_WORD + 1 cycles when tx_ready is held at 1.
- Reset asserted mid-word: the word is dropped, tx_valid falls immediately, and no partial completion is signalled.
- The rr pointer wraps NUM_REQ-1 → 0. Byte and gap counters never exceed their terminal values.

Decomposition:
- Shared package uart_pkg:
  - state encoding ST_IDLE=0, ST_SEND=1, ST_GAP=2;
  - UART_WORD_W=32, UART_BYTE_W=8.
- One sub-module, rr_arbiter: request vector + pointer in, one-hot grant + index out, purely combinational. Reusable for the bus side.
- The shift register, counters and FSM stay in uart_word_arbiter.

Test Plan:
- Single word: NUM_REQ=2, req_valid=01, data0=0xDEADBEEF, tx_ready=1 → req_ready=01 for one cycle; tx_byte 0xDE,0xAD,0xBE,0xEF on 4 consecutive cycles; busy falls after the 4th transfer; grant_id=0.
- Round-robin: both requesters held valid, data0=0x11111111, data1=0x22222222, 4 words → grants in order 0,1,0,1; bytes never interleave within a word.
- Backpressure: tx_ready=0 for 10 cycles after the first byte of 0xA5C30F96 → tx_byte stays 0xA5 with tx_valid=1 throughout; output resumes 0xC3,0x0F,0x96.
- Gap: GAP_CYCLES=3, back-to-back words → exactly 3 cycles with busy=1, tx_valid=0 before next req_ready; with GAP_CYCLES=0 exactly 1 cycle between last byte and next first byte.
- Reset mid-word: assert reset after 2 bytes → tx_valid=0 and busy=0 asynchronously; after release, requester 0 wins first even if requester 1 was mid-word.
- Drop valid: req_valid[0] deasserted after capture → all 4 bytes still sent; no further req_ready to requester 0.
